host_uart_frame_assembler: RTL and testbench

HOST_UART_FRAME_ASSEMBLER -- requirements
Module: host_uart_frame_assembler

---
 rtl/host_uart_pkg.sv | 18 +
 rtl/host_uart_timeout.sv | 31 +++
 rtl/host_uart_frame_assembler.sv | 147 ++++++++++++++
 tb/tb_host_uart_frame_assembler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_uart_pkg.sv
// Shared definitions for the host UART frame assembler.
//   SOF     : start-of-frame byte value
//   MAX_LEN : largest payload length accepted in the LEN byte
//   state_e : assembler state encoding
package host_uart_pkg;

  localparam logic [7:0]  SOF     = 8'h7E;
  localparam int unsigned MAX_LEN = 128;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StCheck,
    StDeliver
  } state_e;

endpackage

// File: rtl/host_uart_timeout.sv
// Inter-byte timeout counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the counter (takes priority over enable)
//   enable       : count one cycle
//   expired      : high while enabled in the TIMEOUT_CYCLES-th counted cycle
module host_uart_timeout #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt_q;

  assign expired = enable && (cnt_q == TIMEOUT_CYCLES - 16'd1);

  // Holds at the terminal value; the owner leaves its counting states on expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/host_uart_frame_assembler.sv
// Assembles SOF/LEN/payload/CHK frames from a UART byte stream and hands the
// payload to a command decoder.
//   clk, reset_n           : clock, asynchronous active-low reset
//   rx_data, rx_valid      : received byte and its one-cycle strobe
//   dec_done               : decoder ready to accept a new frame
//   frame_data, frame_len  : assembled payload (byte k at [8k+7:8k]) and length
//   start                  : one-cycle handoff pulse
//   err_*                  : one-cycle error pulses (at most one per cycle)
//   busy                   : high whenever not idle
module host_uart_frame_assembler #(
  parameter logic [15:0]  TIMEOUT_CYCLES = 16'd50000,
  parameter int unsigned  MAX_LEN        = host_uart_pkg::MAX_LEN
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          dec_done,
  output logic [1023:0] frame_data,
  output logic [7:0]    frame_len,
  output logic          start,
  output logic          err_length,
  output logic          err_checksum,
  output logic          err_timeout,
  output logic          err_overrun,
  output logic          busy
);

  import host_uart_pkg::*;

  localparam logic [8:0] MaxLen9 = 9'(MAX_LEN);

  state_e          state_q, state_d;
  logic [1023:0]   frame_data_q, frame_data_d;
  logic [7:0]      frame_len_q, frame_len_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      xor_q, xor_d;
  logic            to_enable, to_clear, to_expired, timeout_hit;

  assign to_enable = (state_q == StLen) || (state_q == StPayload) || (state_q == StCheck);
  assign to_clear  = rx_valid || !to_enable;
  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout_hit = to_expired && !rx_valid;

  host_uart_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  always_comb begin
    state_d      = state_q;
    frame_data_d = frame_data_q;
    frame_len_d  = frame_len_q;
    idx_d        = idx_q;
    xor_d        = xor_q;
    start        = 1'b0;
    err_length   = 1'b0;
    err_checksum = 1'b0;
    err_timeout  = 1'b0;
    err_overrun  = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_valid && rx_data == SOF) begin
          state_d      = StLen;
          frame_data_d = '0;
          xor_d        = '0;
          idx_d        = '0;
        end
      end
      StLen: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || {1'b0, rx_data} > MaxLen9) begin
            err_length = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_len_d = rx_data;
            state_d     = StPayload;
          end
        end
      end
      StPayload: begin
        if (rx_valid) begin
          frame_data_d[{idx_q[6:0], 3'b000} +: 8] = rx_data;
          xor_d = xor_q ^ rx_data;
          idx_d = idx_q + 8'd1;
          if (idx_q == frame_len_q - 8'd1) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (rx_valid) begin
          if (rx_data == xor_q) begin
            state_d = StDeliver;
          end else begin
            err_checksum = 1'b1;
            state_d      = StIdle;
          end
        end
      end
      StDeliver: begin
        // No room for another frame until the decoder takes this one.
        if (rx_valid) begin
          err_overrun = 1'b1;
        end
        if (dec_done) begin
          start   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Only reachable in LEN/PAYLOAD/CHECK with no byte this cycle.
    if (timeout_hit) begin
      err_timeout = 1'b1;
      state_d     = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      frame_data_q <= '0;
      frame_len_q  <= '0;
      idx_q        <= '0;
      xor_q        <= '0;
    end else begin
      state_q      <= state_d;
      frame_data_q <= frame_data_d;
      frame_len_q  <= frame_len_d;
      idx_q        <= idx_d;
      xor_q        <= xor_d;
    end
  end

  assign frame_data = frame_data_q;
  assign frame_len  = frame_len_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_host_uart_frame_assembler.sv
module tb_host_uart_frame_assembler;

  logic          clk;
  logic          reset_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          dec_done;
  logic [1023:0] frame_data;
  logic [7:0]    frame_len;
  logic          start;
  logic          err_length, err_checksum, err_timeout, err_overrun;
  logic          busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Pulse counters, sampled on the falling edge.
  int start_cnt = 0, len_cnt = 0, ck_cnt = 0, to_cnt = 0, ov_cnt = 0, multi_cnt = 0;

  host_uart_frame_assembler #(
    .TIMEOUT_CYCLES(16'd20),
    .MAX_LEN       (128)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .dec_done    (dec_done),
    .frame_data  (frame_data),
    .frame_len   (frame_len),
    .start       (start),
    .err_length  (err_length),
    .err_checksum(err_checksum),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      start_cnt += int'(start);
      len_cnt   += int'(err_length);
      ck_cnt    += int'(err_checksum);
      to_cnt    += int'(err_timeout);
      ov_cnt    += int'(err_overrun);
      if (int'(err_length) + int'(err_checksum) + int'(err_timeout) + int'(err_overrun) > 1)
        multi_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Called at posedge+1; returns at posedge+1 of the following cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; dec_done = 1'b0;
    repeat (2) @(posedge clk); #1;
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++;
    if (frame_len !== 8'h00) begin
      err_cnt++; $display("FAIL reset_len: got %h want 00", frame_len);
    end
    vec_cnt++;
    if (frame_data !== '0) begin err_cnt++; $display("FAIL reset_data: got %h want 0", frame_data); end
    vec_cnt++;
    if ({start, err_length, err_checksum, err_timeout, err_overrun} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_pulses: got %b want 00000",
               {start, err_length, err_checksum, err_timeout, err_overrun});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    int s0, t0;
    logic [1023:0] exp;
    dec_done = 1'b1;
    t0 = to_cnt;
    // Frame stalled in CHECK; must time out.
    send_byte(8'h7E); send_byte(8'h03); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h01);
    repeat (25) @(posedge clk); #1;
    vec_cnt++;
    if (to_cnt - t0 !== 1) begin err_cnt++; $display("FAIL stall_timeout: got %0d want 1", to_cnt - t0); end
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL stall_idle: busy got %b want 0", busy); end
    s0 = start_cnt;
    send_byte(8'h7E); send_byte(8'h03); send_byte(8'h03); send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk);
    vec_cnt++;
    if (start !== 1'b0) begin err_cnt++; $display("FAIL good_early_start: got %b want 0", start); end
    @(posedge clk); #1;
    send_byte(8'h12);
    @(negedge clk);
    exp = '0;
    exp[23:0] = 24'hBBAA03;
    vec_cnt++;
    if (start !== 1'b1) begin err_cnt++; $display("FAIL good_start: got %b want 1", start); end
    vec_cnt++;
    if (frame_len !== 8'd3) begin err_cnt++; $display("FAIL good_len: got %h want 03", frame_len); end
    vec_cnt++;
    if (frame_data !== exp) begin
      err_cnt++; $display("FAIL good_data: got %h want %h", frame_data, exp);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (start_cnt - s0 !== 1) begin err_cnt++; $display("FAIL good_start_count: got %0d want 1", start_cnt - s0); end
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL good_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_checksum();
    int c0, s0;
    logic [15:0] lo;
    c0 = ck_cnt; s0 = start_cnt;
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    @(posedge clk); #1;
    lo = frame_data[15:0];
    vec_cnt++;
    if (ck_cnt - c0 !== 1) begin err_cnt++; $display("FAIL chk_err: got %0d want 1", ck_cnt - c0); end
    vec_cnt++;
    if (start_cnt - s0 !== 0) begin err_cnt++; $display("FAIL chk_nostart: got %0d want 0", start_cnt - s0); end
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL chk_idle: busy got %b want 0", busy); end
    vec_cnt++;
    if (frame_len !== 8'd2 || lo !== 16'h0201) begin
      err_cnt++; $display("FAIL chk_retain: got len %h data %h want 02 0201", frame_len, lo);
    end
  endtask

  task automatic test_length();
    int l0, s0, t0;
    l0 = len_cnt; s0 = start_cnt; t0 = to_cnt;
    send_byte(8'h7E); send_byte(8'h00);
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL len0_idle: busy got %b want 0", busy); end
    vec_cnt++;
    if (frame_data !== '0) begin err_cnt++; $display("FAIL sof_clear: got %h want 0", frame_data); end
    send_byte(8'h7E); send_byte(8'h81);
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL len81_idle: busy got %b want 0", busy); end
    vec_cnt++;
    if (len_cnt - l0 !== 2) begin err_cnt++; $display("FAIL len_err: got %0d want 2", len_cnt - l0); end
    // 128 is the largest legal length.
    send_byte(8'h7E); send_byte(8'h80);
    vec_cnt++;
    if (busy !== 1'b1 || frame_len !== 8'h80) begin
      err_cnt++; $display("FAIL len80_accept: got busy %b len %h want 1 80", busy, frame_len);
    end
    repeat (22) @(posedge clk); #1;
    vec_cnt++;
    if (to_cnt - t0 !== 1 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL len80_timeout: got %0d busy %b want 1 0", to_cnt - t0, busy);
    end
    vec_cnt++;
    if (start_cnt - s0 !== 0 || len_cnt - l0 !== 2) begin
      err_cnt++; $display("FAIL len_nostart: got start %0d lenerr %0d want 0 2",
                          start_cnt - s0, len_cnt - l0);
    end
  endtask

  task automatic test_overrun();
    int o0, s0;
    logic [1023:0] exp;
    dec_done = 1'b0;
    exp = '0;
    exp[15:0] = 16'h107E;
    // SOF value inside the payload is plain data.
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'h7E); send_byte(8'h10); send_byte(8'h6E);
    o0 = ov_cnt; s0 = start_cnt;
    repeat (3) @(posedge clk); #1;
    send_byte(8'h55);
    vec_cnt++;
    if (ov_cnt - o0 !== 1) begin err_cnt++; $display("FAIL ovr_err: got %0d want 1", ov_cnt - o0); end
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL ovr_stay: busy got %b want 1", busy); end
    repeat (5) @(posedge clk); #1;
    vec_cnt++;
    if (start_cnt - s0 !== 0) begin err_cnt++; $display("FAIL ovr_early: got %0d want 0", start_cnt - s0); end
    vec_cnt++;
    if (frame_data !== exp || frame_len !== 8'd2) begin
      err_cnt++; $display("FAIL ovr_data: got len %h data %h want 02 %h", frame_len, frame_data, exp);
    end
    dec_done = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (start !== 1'b1) begin err_cnt++; $display("FAIL ovr_start: got %b want 1", start); end
    @(posedge clk); #1;
    vec_cnt++;
    if (busy !== 1'b0 || start_cnt - s0 !== 1) begin
      err_cnt++; $display("FAIL ovr_done: got busy %b starts %0d want 0 1", busy, start_cnt - s0);
    end
  endtask

  task automatic test_timeout();
    int s0, t0;
    logic [7:0] b0;
    dec_done = 1'b1;
    send_byte(8'h7E); send_byte(8'h04); send_byte(8'h11);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (err_timeout !== (i == 20)) begin
        err_cnt++; $display("FAIL timeout_cycle%0d: got %b want %b", i, err_timeout, i == 20);
      end
      @(posedge clk); #1;
    end
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL timeout_idle: busy got %b want 0", busy); end
    s0 = start_cnt;
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA5);
    @(posedge clk); #1;
    b0 = frame_data[7:0];
    vec_cnt++;
    if (start_cnt - s0 !== 1 || b0 !== 8'hA5 || frame_len !== 8'd1) begin
      err_cnt++; $display("FAIL after_timeout: got starts %0d byte %h len %h want 1 a5 01",
                          start_cnt - s0, b0, frame_len);
    end
    // Byte arriving exactly in the expiry cycle must be taken.
    s0 = start_cnt; t0 = to_cnt;
    send_byte(8'h7E); send_byte(8'h01);
    repeat (19) @(posedge clk); #1;
    send_byte(8'h3C); send_byte(8'h3C);
    @(posedge clk); #1;
    vec_cnt++;
    if (to_cnt - t0 !== 0 || start_cnt - s0 !== 1) begin
      err_cnt++; $display("FAIL byte_wins: got timeouts %0d starts %0d want 0 1",
                          to_cnt - t0, start_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    s0 = start_cnt;
    send_byte(8'h7E); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02);
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if (busy !== 1'b0 || frame_len !== 8'h00 || frame_data !== '0 || start !== 1'b0) begin
      err_cnt++; $display("FAIL midreset_outputs: got busy %b len %h start %b want 0 00 0",
                          busy, frame_len, start);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h03);
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL midreset_nosof: busy got %b want 0", busy); end
    repeat (3) @(posedge clk); #1;
    vec_cnt++;
    if (start_cnt - s0 !== 0) begin err_cnt++; $display("FAIL midreset_nostart: got %0d want 0", start_cnt - s0); end
    vec_cnt++;
    if (multi_cnt !== 0) begin err_cnt++; $display("FAIL err_exclusive: got %0d want 0", multi_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_checksum();
    test_length();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
